// File: rtl/btn_pkg.sv
// Shared types and defaults for the front-panel button logic.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_e;

  localparam int unsigned HoldTicksDefault   = 500;
  localparam int unsigned RepeatTicksDefault = 100;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into single-cycle press, release, long-press and
// auto-repeat events, timed by an external tick enable.
module button_event_gen
  import btn_pkg::*;
#(
  parameter int unsigned HOLD_TICKS   = HoldTicksDefault,
  parameter int unsigned REPEAT_TICKS = RepeatTicksDefault,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pb_db,
  input  logic tick,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic pressed
);

  localparam int unsigned CNT_W = $clog2(max_u(HOLD_TICKS, REPEAT_TICKS));
  localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_TICKS - 1);

  logic             s2;
  logic             s3;
  logic             rise;
  logic             fall;
  logic             rise_q;
  logic             fall_q;
  btn_state_e       state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pb_db),
    .q       (s2)
  );

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign pressed = s3;

  // Edge strobes are registered so every event lands three cycles after pb_db is sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3     <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s3     <= s2;
      rise_q <= rise;
      fall_q <= fall;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_q) begin
            press_pulse <= 1'b1;
            cnt         <= '0;
            state       <= PRESSED;
          end
        end
        PRESSED: begin
          // Release wins over a coincident tick.
          if (fall_q) begin
            release_pulse <= 1'b1;
            cnt           <= '0;
            state         <= IDLE;
          end else if (tick) begin
            if (cnt == HoldLast) begin
              long_pulse <= 1'b1;
              cnt        <= '0;
              state      <= HELD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HELD: begin
          if (fall_q) begin
            release_pulse <= 1'b1;
            cnt           <= '0;
            state         <= IDLE;
          end else if (tick) begin
            // Without repeat the counter parks at its last value.
            if (cnt == RepeatLast) begin
              if (REPEAT_EN) begin
                repeat_pulse <= 1'b1;
                cnt          <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  a_one_pulse: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0({press_pulse, release_pulse, long_pulse, repeat_pulse}));

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen: a repeat-enabled and a repeat-disabled instance
// share the same stimulus.
module tb_button_event_gen;

  logic clk = 1'b0;
  logic reset_n;
  logic pb_db;
  logic tick;

  logic press_pulse, release_pulse, long_pulse, repeat_pulse, pressed;
  logic nr_press, nr_release, nr_long, nr_repeat, nr_pressed;
  logic [9:0] all_outs;

  assign all_outs = {press_pulse, release_pulse, long_pulse, repeat_pulse, pressed,
                     nr_press, nr_release, nr_long, nr_repeat, nr_pressed};

  button_event_gen #(
    .HOLD_TICKS   (4),
    .REPEAT_TICKS (2),
    .REPEAT_EN    (1'b1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pb_db         (pb_db),
    .tick          (tick),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .pressed       (pressed)
  );

  button_event_gen #(
    .HOLD_TICKS   (4),
    .REPEAT_TICKS (2),
    .REPEAT_EN    (1'b0)
  ) dut_nr (
    .clk           (clk),
    .reset_n       (reset_n),
    .pb_db         (pb_db),
    .tick          (tick),
    .press_pulse   (nr_press),
    .release_pulse (nr_release),
    .long_pulse    (nr_long),
    .repeat_pulse  (nr_repeat),
    .pressed       (nr_pressed)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int unsigned ticks;
    bit          gap;
    bit          tick_on_press;
    int          exp_long;
    int          exp_long_at;
    int          exp_rep;
    int          exp_rep1_at;
    int          exp_long_nr;
    int          exp_rep_nr;
  } vec_t;

  vec_t vecs[7];

  int n_checks = 0;
  int n_fail   = 0;
  int cp, cr, cl, crp, cp_n, cr_n, cl_n, crp_n;
  int overlap = 0;
  int press_at, pressed_at, long_at, rep1_at, tk_n;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    cp = 0; cr = 0; cl = 0; crp = 0;
    cp_n = 0; cr_n = 0; cl_n = 0; crp_n = 0;
  endtask

  // Called at a negedge; drives inputs, samples 1 time unit after the posedge, returns at negedge.
  task automatic step(input logic pb, input logic tk);
    pb_db = pb;
    tick  = tk;
    @(posedge clk);
    #1;
    cp  += int'(press_pulse);
    cr  += int'(release_pulse);
    cl  += int'(long_pulse);
    crp += int'(repeat_pulse);
    cp_n  += int'(nr_press);
    cr_n  += int'(nr_release);
    cl_n  += int'(nr_long);
    crp_n += int'(nr_repeat);
    if (int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse) > 1)
      overlap++;
    if (int'(nr_press) + int'(nr_release) + int'(nr_long) + int'(nr_repeat) > 1)
      overlap++;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    clear_counts();
    press_at = 0; long_at = 0; rep1_at = 0; tk_n = 0;
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, v.tick_on_press);
      if (press_at == 0 && cp > 0) press_at = i;
    end
    while (tk_n < int'(v.ticks)) begin
      if (v.gap) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      tk_n++;
      if (long_at == 0 && cl > 0) long_at = tk_n;
      if (rep1_at == 0 && crp > 0) rep1_at = tk_n;
    end
    check($sformatf("v%0d_pressed_hold", idx), int'(pressed), 1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    check($sformatf("v%0d_press_cnt", idx), cp, 1);
    check($sformatf("v%0d_press_at", idx), press_at, 4);
    check($sformatf("v%0d_release_cnt", idx), cr, 1);
    check($sformatf("v%0d_long_cnt", idx), cl, v.exp_long);
    check($sformatf("v%0d_long_at", idx), long_at, v.exp_long_at);
    check($sformatf("v%0d_repeat_cnt", idx), crp, v.exp_rep);
    check($sformatf("v%0d_repeat1_at", idx), rep1_at, v.exp_rep1_at);
    check($sformatf("v%0d_pressed_after", idx), int'(pressed), 0);
    check($sformatf("v%0d_nr_long_cnt", idx), cl_n, v.exp_long_nr);
    check($sformatf("v%0d_nr_repeat_cnt", idx), crp_n, v.exp_rep_nr);
    check($sformatf("v%0d_nr_release_cnt", idx), cr_n, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ticks, gap, tick_on_press, long, long_at, rep, rep1_at, nr_long, nr_rep
    vecs[0] = '{3,  1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{9,  1'b0, 1'b0, 1, 4, 2, 6, 1, 0};
    vecs[2] = '{20, 1'b1, 1'b0, 1, 4, 8, 6, 1, 0};
    vecs[3] = '{4,  1'b0, 1'b1, 1, 4, 0, 0, 1, 0};
    vecs[4] = '{6,  1'b1, 1'b1, 1, 4, 1, 6, 1, 0};
    vecs[5] = '{5,  1'b0, 1'b0, 1, 4, 0, 0, 1, 0};
    vecs[6] = '{1,  1'b1, 1'b1, 0, 0, 0, 0, 0, 0};

    // Reset held with the button down, then press appears on the 4th edge after release.
    reset_n = 1'b0;
    pb_db   = 1'b1;
    tick    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'(all_outs), 0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_counts();
    press_at = 0; pressed_at = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0);
      if (press_at == 0 && cp > 0) press_at = i;
      if (pressed_at == 0 && pressed) pressed_at = i;
    end
    check("rst_press_at", press_at, 4);
    check("rst_press_cnt", cp, 1);
    check("rst_pressed_at", pressed_at, 3);
    check("rst_nr_press_cnt", cp_n, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    check("rst_release_cnt", cr, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Release reaches the FSM on the same edge as the 4th tick.
    clear_counts();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("fall_tick_release_now", cr, 1);
    check("fall_tick_no_long", cl, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    press_at = 0;
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0);
      if (press_at == 0 && cp > 1) press_at = i;
    end
    check("fall_tick_repress_at", press_at, 4);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    check("fall_tick_long_total", cl + cl_n + crp + crp_n, 0);
    check("fall_tick_release_total", cr, 2);

    // Asynchronous reset while HELD aborts without a release pulse.
    clear_counts();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    check("held_long_cnt", cl, 1);
    check("held_pressed", int'(pressed), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", int'(all_outs), 0);
    @(negedge clk);
    pb_db = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    clear_counts();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    check("abort_no_release", cr + cr_n, 0);
    check("abort_no_press", cp + cp_n, 0);
    run_vec(vecs[1], 7);

    check("no_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
